// File: rtl/mrv1_thread_ctl.sv
// mrv1_thread_ctl: per-thread lifecycle state and round-robin fetch-PC selection.
module mrv1_thread_ctl #(
    parameter int NUM_THREADS_P = 4,
    parameter int PC_WIDTH_P = 32,
    parameter logic [PC_WIDTH_P-1:0] RESET_PC_P = '0,
    localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     th_ctl_vld_i,
    input  logic [TID_WIDTH_LP-1:0]  th_ctl_tid_i,
    input  logic                     th_ctl_tspawn_vld_i,
    input  logic [PC_WIDTH_P-1:0]    th_ctl_tspawn_pc_i,
    input  logic                     br_vld_i,
    input  logic [TID_WIDTH_LP-1:0]  br_tid_i,
    input  logic [PC_WIDTH_P-1:0]    br_pc_i,
    input  logic                     stall_vld_i,
    input  logic [TID_WIDTH_LP-1:0]  stall_tid_i,
    input  logic                     resume_vld_i,
    input  logic [TID_WIDTH_LP-1:0]  resume_tid_i,
    output logic                     fetch_vld_o,
    input  logic                     fetch_rdy_i,
    output logic [TID_WIDTH_LP-1:0]  fetch_tid_o,
    output logic [PC_WIDTH_P-1:0]    fetch_pc_o,
    output logic [NUM_THREADS_P-1:0] active_mask_o,
    output logic                     spawn_err_o
);
    typedef enum logic [1:0] {IDLE, READY, STALLED} th_state_t;

    th_state_t                st [NUM_THREADS_P];
    logic [PC_WIDTH_P-1:0]    pc [NUM_THREADS_P];
    logic [TID_WIDTH_LP-1:0]  rr_ptr;
    logic [TID_WIDTH_LP-1:0]  sel;
    logic [TID_WIDTH_LP-1:0]  sel_next;
    logic [NUM_THREADS_P-1:0] ready;
    logic                     fire;

    // Scan from the farthest slot back toward rr_ptr so the last hit is the first READY in RR order.
    always_comb begin
        sel = '0;
        for (int t = 0; t < NUM_THREADS_P; t++) begin
            ready[t] = st[t] == READY;
            active_mask_o[t] = st[t] != IDLE;
        end
        for (int i = NUM_THREADS_P - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_ptr) + i;
            j = j >= NUM_THREADS_P ? j - NUM_THREADS_P : j;
            sel = ready[j] ? TID_WIDTH_LP'(j) : sel;
        end
        fetch_vld_o = |ready;
        fetch_tid_o = fetch_vld_o ? sel : '0;
        fetch_pc_o  = fetch_vld_o ? pc[sel] : '0;
        fire        = fetch_vld_o & fetch_rdy_i;
        sel_next    = int'(sel) == NUM_THREADS_P - 1 ? '0 : sel + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int t = 0; t < NUM_THREADS_P; t++) begin
                st[t] <= t == 0 ? READY : IDLE;
                pc[t] <= t == 0 ? RESET_PC_P : '0;
            end
            rr_ptr <= '0;
            spawn_err_o <= 1'b0;
        end else begin
            if (fire)
                rr_ptr <= sel_next;
            for (int t = 0; t < NUM_THREADS_P; t++) begin
                logic hit, term, spawn;
                hit   = th_ctl_vld_i && int'(th_ctl_tid_i) == t;
                term  = hit && !th_ctl_tspawn_vld_i;
                spawn = hit && th_ctl_tspawn_vld_i && st[t] == IDLE;
                if (hit && th_ctl_tspawn_vld_i && st[t] != IDLE)
                    spawn_err_o <= 1'b1;
                if (term)
                    st[t] <= IDLE;
                else if (spawn)
                    st[t] <= READY;
                else if (stall_vld_i && int'(stall_tid_i) == t && st[t] == READY)
                    st[t] <= STALLED;
                else if (resume_vld_i && int'(resume_tid_i) == t && st[t] == STALLED)
                    st[t] <= READY;
                if (term)
                    pc[t] <= pc[t];
                else if (spawn)
                    pc[t] <= {th_ctl_tspawn_pc_i[PC_WIDTH_P-1:2], 2'b00};
                else if (br_vld_i && int'(br_tid_i) == t && st[t] != IDLE)
                    pc[t] <= {br_pc_i[PC_WIDTH_P-1:2], 2'b00};
                else if (fire && int'(sel) == t)
                    pc[t] <= pc[t] + PC_WIDTH_P'(4);
            end
        end
    end
endmodule

// File: tb/tb_mrv1_thread_ctl.sv
// tb_mrv1_thread_ctl: directed scenario tests for the thread controller.
module tb_mrv1_thread_ctl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        th_ctl_vld = 1'b0;
    logic [1:0]  th_ctl_tid = '0;
    logic        th_ctl_tspawn_vld = 1'b0;
    logic [31:0] th_ctl_tspawn_pc = '0;
    logic        br_vld = 1'b0;
    logic [1:0]  br_tid = '0;
    logic [31:0] br_pc = '0;
    logic        stall_vld = 1'b0;
    logic [1:0]  stall_tid = '0;
    logic        resume_vld = 1'b0;
    logic [1:0]  resume_tid = '0;
    logic        fetch_vld;
    logic        fetch_rdy = 1'b0;
    logic [1:0]  fetch_tid;
    logic [31:0] fetch_pc;
    logic [3:0]  active_mask;
    logic        spawn_err;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mrv1_thread_ctl dut (
        .clk_i(clk), .rst_i(rst),
        .th_ctl_vld_i(th_ctl_vld), .th_ctl_tid_i(th_ctl_tid),
        .th_ctl_tspawn_vld_i(th_ctl_tspawn_vld), .th_ctl_tspawn_pc_i(th_ctl_tspawn_pc),
        .br_vld_i(br_vld), .br_tid_i(br_tid), .br_pc_i(br_pc),
        .stall_vld_i(stall_vld), .stall_tid_i(stall_tid),
        .resume_vld_i(resume_vld), .resume_tid_i(resume_tid),
        .fetch_vld_o(fetch_vld), .fetch_rdy_i(fetch_rdy),
        .fetch_tid_o(fetch_tid), .fetch_pc_o(fetch_pc),
        .active_mask_o(active_mask), .spawn_err_o(spawn_err)
    );

    task automatic clear_cmds();
        th_ctl_vld = 1'b0;
        br_vld = 1'b0;
        stall_vld = 1'b0;
        resume_vld = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({fetch_vld, fetch_tid, fetch_pc} !== {1'b1, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL reset_offer got vld=%b tid=%0d pc=%h want 1/0/0", fetch_vld, fetch_tid, fetch_pc);
        end
        checks++;
        if ({active_mask, spawn_err} !== {4'b0001, 1'b0}) begin
            failures++;
            $display("FAIL reset_mask got mask=%b err=%b want 0001/0", active_mask, spawn_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch_seq();
        fetch_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({fetch_vld, fetch_tid, fetch_pc} !== {1'b1, 2'd0, 32'(4 * i)}) begin
                failures++;
                $display("FAIL fetch_seq[%0d] got vld=%b tid=%0d pc=%h want 1/0/%h", i, fetch_vld, fetch_tid, fetch_pc, 4 * i);
            end
            @(negedge clk);
        end
        checks++;
        if (active_mask !== 4'b0001) begin
            failures++;
            $display("FAIL fetch_seq_mask got %b want 0001", active_mask);
        end
    endtask

    task automatic test_spawn();
        logic [1:0]  exp_tid [4] = '{2'd2, 2'd0, 2'd2, 2'd0};
        logic [31:0] exp_pc  [4] = '{32'h100, 32'h10, 32'h104, 32'h14};
        th_ctl_vld = 1'b1;
        th_ctl_tid = 2'd2;
        th_ctl_tspawn_vld = 1'b1;
        th_ctl_tspawn_pc = 32'h103;
        @(negedge clk);
        clear_cmds();
        checks++;
        if (active_mask !== 4'b0101) begin
            failures++;
            $display("FAIL spawn_mask got %b want 0101", active_mask);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({fetch_vld, fetch_tid, fetch_pc} !== {1'b1, exp_tid[i], exp_pc[i]}) begin
                failures++;
                $display("FAIL spawn_alt[%0d] got tid=%0d pc=%h want %0d/%h", i, fetch_tid, fetch_pc, exp_tid[i], exp_pc[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_spawn_err();
        fetch_rdy = 1'b0;
        th_ctl_vld = 1'b1;
        th_ctl_tid = 2'd0;
        th_ctl_tspawn_vld = 1'b1;
        th_ctl_tspawn_pc = 32'h999;
        @(negedge clk);
        clear_cmds();
        checks++;
        if ({spawn_err, fetch_tid, fetch_pc} !== {1'b1, 2'd2, 32'h108}) begin
            failures++;
            $display("FAIL spawn_err got err=%b tid=%0d pc=%h want 1/2/108", spawn_err, fetch_tid, fetch_pc);
        end
        fetch_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({spawn_err, fetch_tid, fetch_pc} !== {1'b1, 2'd0, 32'h18}) begin
            failures++;
            $display("FAIL spawn_err_pc got err=%b tid=%0d pc=%h want 1/0/18", spawn_err, fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_redirect();
        br_vld = 1'b1;
        br_tid = 2'd0;
        br_pc = 32'h201;
        @(negedge clk);
        clear_cmds();
        checks++;
        if ({fetch_tid, fetch_pc} !== {2'd2, 32'h10C}) begin
            failures++;
            $display("FAIL redirect_other got tid=%0d pc=%h want 2/10c", fetch_tid, fetch_pc);
        end
        @(negedge clk);
        fetch_rdy = 1'b0;
        checks++;
        if ({fetch_tid, fetch_pc} !== {2'd0, 32'h200}) begin
            failures++;
            $display("FAIL redirect_pc got tid=%0d pc=%h want 0/200", fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_stall();
        th_ctl_vld = 1'b1;
        th_ctl_tid = 2'd2;
        th_ctl_tspawn_vld = 1'b0;
        @(negedge clk);
        clear_cmds();
        checks++;
        if ({active_mask, fetch_tid, fetch_pc} !== {4'b0001, 2'd0, 32'h200}) begin
            failures++;
            $display("FAIL term_idle got mask=%b tid=%0d pc=%h want 0001/0/200", active_mask, fetch_tid, fetch_pc);
        end
        stall_vld = 1'b1;
        stall_tid = 2'd0;
        @(negedge clk);
        clear_cmds();
        checks++;
        if ({fetch_vld, fetch_tid, fetch_pc} !== {1'b0, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL stall got vld=%b tid=%0d pc=%h want 0/0/0", fetch_vld, fetch_tid, fetch_pc);
        end
        resume_vld = 1'b1;
        resume_tid = 2'd0;
        @(negedge clk);
        clear_cmds();
        checks++;
        if ({fetch_vld, fetch_tid, fetch_pc} !== {1'b1, 2'd0, 32'h200}) begin
            failures++;
            $display("FAIL resume got vld=%b tid=%0d pc=%h want 1/0/200", fetch_vld, fetch_tid, fetch_pc);
        end
        stall_vld = 1'b1;
        resume_vld = 1'b1;
        @(negedge clk);
        clear_cmds();
        checks++;
        if (fetch_vld !== 1'b0) begin
            failures++;
            $display("FAIL stall_wins got vld=%b want 0", fetch_vld);
        end
        resume_vld = 1'b1;
        @(negedge clk);
        clear_cmds();
    endtask

    task automatic test_terminate_handshake();
        th_ctl_vld = 1'b1;
        th_ctl_tid = 2'd1;
        th_ctl_tspawn_vld = 1'b1;
        th_ctl_tspawn_pc = 32'h40;
        @(negedge clk);
        clear_cmds();
        checks++;
        if ({active_mask, fetch_vld, fetch_tid, fetch_pc} !== {4'b0011, 1'b1, 2'd0, 32'h200}) begin
            failures++;
            $display("FAIL spawn_t1 got mask=%b vld=%b tid=%0d pc=%h want 0011/1/0/200", active_mask, fetch_vld, fetch_tid, fetch_pc);
        end
        th_ctl_vld = 1'b1;
        th_ctl_tid = 2'd0;
        th_ctl_tspawn_vld = 1'b0;
        fetch_rdy = 1'b1;
        @(negedge clk);
        clear_cmds();
        fetch_rdy = 1'b0;
        checks++;
        if ({active_mask, fetch_tid, fetch_pc} !== {4'b0010, 2'd1, 32'h40}) begin
            failures++;
            $display("FAIL term_handshake got mask=%b tid=%0d pc=%h want 0010/1/40", active_mask, fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_async_reset();
        fetch_rdy = 1'b1;
        repeat (2) @(negedge clk);
        fetch_rdy = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({fetch_vld, fetch_tid, fetch_pc, active_mask, spawn_err} !== {1'b1, 2'd0, 32'h0, 4'b0001, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got vld=%b tid=%0d pc=%h mask=%b err=%b want 1/0/0/0001/0",
                     fetch_vld, fetch_tid, fetch_pc, active_mask, spawn_err);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({fetch_vld, fetch_tid, fetch_pc} !== {1'b1, 2'd0, 32'h0}) begin
            failures++;
            $display("FAIL post_reset got vld=%b tid=%0d pc=%h want 1/0/0", fetch_vld, fetch_tid, fetch_pc);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_spawn();
        test_spawn_err();
        test_redirect();
        test_stall();
        test_terminate_handshake();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
